// File: rtl/cpu_multicycle_pkg.sv
// Shared types and decode helpers for the multi-cycle RV32I-subset core.
// The HALT state exists only when CPU_MC_ILLEGAL_TRAP_EN is defined.
package cpu_multicycle_pkg;

  localparam logic [6:0] OP_R   = 7'h33;
  localparam logic [6:0] OP_I   = 7'h13;
  localparam logic [6:0] OP_LW  = 7'h03;
  localparam logic [6:0] OP_SW  = 7'h23;
  localparam logic [6:0] OP_BEQ = 7'h63;
  localparam logic [6:0] OP_JAL = 7'h6F;

  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_R, EXEC_I, ALUWB, MEMADR, MEMREAD, MEMWB, MEMWRITE, BRANCH, JAL
`ifdef CPU_MC_ILLEGAL_TRAP_EN
    , HALT
`endif
  } state_t;

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_t;
  typedef enum logic [1:0] {IMM_I, IMM_S, IMM_B, IMM_J} imm_fmt_t;
  typedef enum logic [1:0] {WB_ALU, WB_MDR, WB_PC} wb_sel_t;

  // Bit 30 selects SUB only for R-type; for OP-IMM it is part of the immediate.
  function automatic alu_op_t alu_decode(input logic [2:0] funct3, input logic funct7b5,
                                         input logic is_r);
    case (funct3)
      3'b000:  return (is_r && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  return ALU_SLT;
      3'b110:  return ALU_OR;
      3'b111:  return ALU_AND;
      default: return ALU_ADD;
    endcase
  endfunction

  function automatic logic [31:0] imm_gen(input logic [31:7] ir, input imm_fmt_t fmt);
    case (fmt)
      IMM_S:   return {{20{ir[31]}}, ir[31:25], ir[11:7]};
      IMM_B:   return {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      IMM_J:   return {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      default: return {{20{ir[31]}}, ir[31:20]};
    endcase
  endfunction

endpackage

// File: rtl/cpu_multicycle_control.sv
// Control FSM for cpu_multicycle: sequences each instruction and drives all enables/selects.
// With CPU_MC_ILLEGAL_TRAP_EN an undefined opcode parks the FSM in HALT until reset.
module mc_control
  import cpu_multicycle_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic      funct7b5,
  input  logic      mem_ready,
  output logic      mem_req,
  output logic      mem_we,
  output logic      addr_from_alu,
  output logic      ir_we,
  output logic      ab_we,
  output logic      aluout_we,
  output logic      alu_a_pc,
  output logic      alu_b_imm,
  output alu_op_t   alu_op,
  output imm_fmt_t  imm_fmt,
  output logic      mdr_we,
  output logic      rf_we,
  output wb_sel_t   wb_sel,
  output logic      branch,
  output logic      jump,
  output logic      retire,
  output logic      halted
);

  state_t state, next;

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= next;
  end

  always_comb begin
    next          = state;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    addr_from_alu = 1'b0;
    ir_we         = 1'b0;
    ab_we         = 1'b0;
    aluout_we     = 1'b0;
    alu_a_pc      = 1'b0;
    alu_b_imm     = 1'b0;
    alu_op        = ALU_ADD;
    imm_fmt       = IMM_I;
    mdr_we        = 1'b0;
    rf_we         = 1'b0;
    wb_sel        = WB_ALU;
    branch        = 1'b0;
    jump          = 1'b0;
    retire        = 1'b0;
    halted        = 1'b0;
    case (state)
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we = 1'b1;
          next  = DECODE;
        end
      end
      DECODE: begin
        // Branch/jump target is precomputed here from old_pc.
        ab_we     = 1'b1;
        aluout_we = 1'b1;
        alu_a_pc  = 1'b1;
        alu_b_imm = 1'b1;
        imm_fmt   = (opcode == OP_JAL) ? IMM_J : IMM_B;
        case (opcode)
          OP_R:         next = EXEC_R;
          OP_I:         next = EXEC_I;
          OP_LW, OP_SW: next = MEMADR;
          OP_BEQ:       next = BRANCH;
          OP_JAL:       next = JAL;
`ifdef CPU_MC_ILLEGAL_TRAP_EN
          default:      next = HALT;
`else
          default: begin
            retire = 1'b1;
            next   = FETCH;
          end
`endif
        endcase
      end
      EXEC_R: begin
        aluout_we = 1'b1;
        alu_op    = alu_decode(funct3, funct7b5, 1'b1);
        next      = ALUWB;
      end
      EXEC_I: begin
        aluout_we = 1'b1;
        alu_b_imm = 1'b1;
        alu_op    = alu_decode(funct3, funct7b5, 1'b0);
        next      = ALUWB;
      end
      ALUWB: begin
        rf_we  = 1'b1;
        retire = 1'b1;
        next   = FETCH;
      end
      MEMADR: begin
        aluout_we = 1'b1;
        alu_b_imm = 1'b1;
        imm_fmt   = (opcode == OP_SW) ? IMM_S : IMM_I;
        next      = (opcode == OP_SW) ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        mem_req       = 1'b1;
        addr_from_alu = 1'b1;
        if (mem_ready) begin
          mdr_we = 1'b1;
          next   = MEMWB;
        end
      end
      MEMWB: begin
        rf_we  = 1'b1;
        wb_sel = WB_MDR;
        retire = 1'b1;
        next   = FETCH;
      end
      MEMWRITE: begin
        mem_req       = 1'b1;
        mem_we        = 1'b1;
        addr_from_alu = 1'b1;
        if (mem_ready) begin
          retire = 1'b1;
          next   = FETCH;
        end
      end
      BRANCH: begin
        branch = 1'b1;
        retire = 1'b1;
        next   = FETCH;
      end
      JAL: begin
        rf_we  = 1'b1;
        wb_sel = WB_PC;
        jump   = 1'b1;
        retire = 1'b1;
        next   = FETCH;
      end
`ifdef CPU_MC_ILLEGAL_TRAP_EN
      HALT: halted = 1'b1;
`endif
      default: next = FETCH;
    endcase
  end

endmodule

// File: rtl/cpu_multicycle.sv
// Multi-cycle RV32I-subset core with a single shared req/ready memory port.
// Define CPU_MC_ILLEGAL_TRAP_EN to halt on undefined opcodes instead of treating them as NOP.
module cpu_multicycle
  import cpu_multicycle_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     NREGS    = 32
) (
  input  logic            clk,
  input  logic            reset,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready,
  output logic            retire,
  output logic [XLEN-1:0] pc_dbg,
  output logic            halted
);

  logic [XLEN-1:0] pc, old_pc, a_q, b_q, alu_out, mdr;
  logic [31:0]     ir;
  logic [XLEN-1:0] regs [NREGS];

  logic     c_req, c_we, addr_from_alu, ir_we, ab_we, aluout_we, alu_a_pc, alu_b_imm;
  logic     mdr_we, rf_we, branch, jump, c_retire, c_halted;
  alu_op_t  alu_op;
  imm_fmt_t imm_fmt;
  wb_sel_t  wb_sel;

  mc_control u_ctrl (
    .clk(clk), .reset(reset), .opcode(ir[6:0]), .funct3(ir[14:12]), .funct7b5(ir[30]),
    .mem_ready(mem_ready), .mem_req(c_req), .mem_we(c_we), .addr_from_alu(addr_from_alu),
    .ir_we(ir_we), .ab_we(ab_we), .aluout_we(aluout_we), .alu_a_pc(alu_a_pc),
    .alu_b_imm(alu_b_imm), .alu_op(alu_op), .imm_fmt(imm_fmt), .mdr_we(mdr_we),
    .rf_we(rf_we), .wb_sel(wb_sel), .branch(branch), .jump(jump), .retire(c_retire),
    .halted(c_halted)
  );

  logic [4:0]      rs1, rs2, rd;
  logic [XLEN-1:0] rs1_val, rs2_val, imm, alu_a, alu_b, alu_y, wb_data, addr_raw;

  assign rs1     = ir[19:15];
  assign rs2     = ir[24:20];
  assign rd      = ir[11:7];
  assign rs1_val = (rs1 == '0) ? '0 : regs[rs1];
  assign rs2_val = (rs2 == '0) ? '0 : regs[rs2];
  assign imm     = XLEN'($signed(imm_gen(ir[31:7], imm_fmt)));

  always_comb begin
    alu_a = alu_a_pc  ? old_pc : a_q;
    alu_b = alu_b_imm ? imm    : b_q;
    alu_y = '0;
    case (alu_op)
      ALU_SUB: alu_y = alu_a - alu_b;
      ALU_AND: alu_y = alu_a & alu_b;
      ALU_OR:  alu_y = alu_a | alu_b;
      ALU_SLT: alu_y[0] = $signed(alu_a) < $signed(alu_b);
      default: alu_y = alu_a + alu_b;
    endcase
  end

  always_comb begin
    case (wb_sel)
      WB_MDR:  wb_data = mdr;
      WB_PC:   wb_data = pc;
      default: wb_data = alu_out;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc      <= RESET_PC;
      old_pc  <= '0;
      ir      <= '0;
      a_q     <= '0;
      b_q     <= '0;
      alu_out <= '0;
      mdr     <= '0;
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      if (ir_we) begin
        ir     <= mem_rdata[31:0];
        old_pc <= pc;
        pc     <= pc + XLEN'(4);
      end
      if (ab_we) begin
        a_q <= rs1_val;
        b_q <= rs2_val;
      end
      if (aluout_we) alu_out <= alu_y;
      if (mdr_we)    mdr     <= mem_rdata;
      if ((branch && (a_q == b_q)) || jump) pc <= alu_out;
      if (rf_we && (rd != '0)) regs[rd] <= wb_data;
    end
  end

  // Outputs are forced quiet during reset so an in-flight access is abandoned immediately.
  assign addr_raw  = addr_from_alu ? alu_out : pc;
  assign mem_req   = c_req & ~reset;
  assign mem_we    = c_we & mem_req;
  assign mem_addr  = mem_req ? {addr_raw[XLEN-1:2], 2'b00} : '0;
  assign mem_wdata = mem_we ? b_q : '0;
  assign retire    = c_retire & ~reset;
  assign halted    = c_halted & ~reset;
  assign pc_dbg    = halted ? old_pc : pc;

endmodule

// File: tb/tb_cpu_multicycle.sv
// Directed bench for cpu_multicycle: hand-assembled programs, wait-state memory, immediate assertions.
module tb_cpu_multicycle;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req, mem_we, mem_ready, retire, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_dbg;

  logic [31:0] mem [0:255];
  int          wait_n = 0;
  int          wcnt = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] st_addr = '0, st_data = '0;
  int          st_cnt = 0;

  always #5 clk = ~clk;

  cpu_multicycle #(.XLEN(32), .RESET_PC(32'h0000_0000), .NREGS(32)) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .retire(retire),
    .pc_dbg(pc_dbg), .halted(halted)
  );

  assign mem_rdata = mem[mem_addr[9:2]];
  assign mem_ready = mem_req && (wcnt >= wait_n);

  always @(posedge clk) begin
    wcnt <= (mem_req && !mem_ready) ? wcnt + 1 : 0;
    if (!reset && mem_req && mem_we && mem_ready) begin
      mem[mem_addr[9:2]] <= mem_wdata;
      st_addr <= mem_addr;
      st_data <= mem_wdata;
      st_cnt  <= st_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // A pending request must stay up with unchanged address/type/data until ready.
  logic        pend = 1'b0, pend_we = 1'b0;
  logic [31:0] pend_addr = '0, pend_data = '0;
  always @(negedge clk) begin
    if (reset) pend = 1'b0;
    else begin
      if (pend) begin
        check("hold_req", {31'b0, mem_req}, 32'd1);
        check("hold_addr", mem_addr, pend_addr);
        check("hold_we", {31'b0, mem_we}, {31'b0, pend_we});
        check("hold_wdata", mem_wdata, pend_data);
      end
      pend      = mem_req && !mem_ready;
      pend_addr = mem_addr;
      pend_we   = mem_we;
      pend_data = mem_wdata;
    end
  end

  function automatic logic [31:0] enc_r(input logic [31:0] f7, rs2, rs1, f3, rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
  endfunction
  function automatic logic [31:0] enc_i(input logic [31:0] imm, rs1, f3, rd, op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] enc_s(input logic [31:0] imm, rs2, rs1);
    return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input logic [31:0] imm, rs2, rs1);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], 3'b000, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_j(input logic [31:0] imm, rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6F};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0013;
  endtask

  task automatic do_reset(input bit chk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (chk) begin
      check("rst_mem_req", {31'b0, mem_req}, 32'd0);
      check("rst_mem_we", {31'b0, mem_we}, 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      check("rst_retire", {31'b0, retire}, 32'd0);
      check("rst_halted", {31'b0, halted}, 32'd0);
    end
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    st_cnt = 0;
    #1;
  endtask

  // Counts cycles up to and including the retire cycle, then steps past the edge.
  task automatic step(input string tag, input int exp_cyc);
    int  cyc;
    bit  seen;
    cyc  = 0;
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      cyc++;
      if (retire === 1'b1) seen = 1'b1;
    end
    @(posedge clk);
    #1;
    check({tag, "_cycles"}, 32'(cyc), 32'(exp_cyc));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_req, n_ret;

    // Arithmetic sequence plus taken branch, zero wait states
    clear_mem();
    mem[0] = enc_i(5, 0, 0, 1, 32'h13);
    mem[1] = enc_i(-3, 0, 0, 2, 32'h13);
    mem[2] = enc_r(0, 2, 1, 0, 3);
    mem[3] = enc_r(0, 1, 2, 2, 4);
    mem[4] = enc_b(-8, 1, 1);
    wait_n = 0;
    do_reset(1'b1);
    check("first_req", {31'b0, mem_req}, 32'd1);
    check("first_addr", mem_addr, 32'h0000_0000);
    for (int i = 0; i < 32; i++) check("reg_after_reset", dut.regs[i], 32'd0);
    step("addi_x1", 4);
    check("x1", dut.regs[1], 32'd5);
    step("addi_x2", 4);
    check("x2", dut.regs[2], 32'hFFFF_FFFD);
    step("add_x3", 4);
    check("x3", dut.regs[3], 32'd2);
    step("slt_x4", 4);
    check("x4", dut.regs[4], 32'd1);
    check("pc_before_beq", pc_dbg, 32'h10);
    step("beq_taken", 3);
    check("pc_beq_taken", pc_dbg, 32'h08);

    // Store/load with two wait states per access
    clear_mem();
    mem[0] = enc_i(5, 0, 0, 1, 32'h13);
    mem[1] = enc_j(12, 0);
    mem[2] = 32'h0000_0000;
    mem[4] = enc_s(8, 1, 0);
    mem[5] = enc_i(8, 0, 2, 5, 32'h03);
    wait_n = 2;
    do_reset(1'b0);
    step("addi_wait", 6);
    step("jal_x0_wait", 5);
    check("pc_jal_x0", pc_dbg, 32'h10);
    check("x0_after_jal", dut.regs[0], 32'd0);
    step("sw_wait", 8);
    check("st_cnt", 32'(st_cnt), 32'd1);
    check("st_addr", st_addr, 32'h8);
    check("st_data", st_data, 32'h5);
    step("lw_wait", 9);
    check("x5", dut.regs[5], 32'd5);
    // Abandon the next fetch mid-wait with reset
    check("fetch_pending", {31'b0, mem_req}, 32'd1);
    reset = 1'b1;
    #1;
    check("abandon_req", {31'b0, mem_req}, 32'd0);
    @(posedge clk);
    #1;
    check("abandon_pc", pc_dbg, 32'h0);
    check("abandon_x5", dut.regs[5], 32'd0);

    // Not-taken branch, more ALU ops, jal with link, illegal opcode
    clear_mem();
    mem[0]  = enc_i(5, 0, 0, 1, 32'h13);
    mem[1]  = enc_i(-3, 0, 0, 2, 32'h13);
    mem[2]  = enc_i(7, 0, 0, 0, 32'h13);
    mem[3]  = enc_i(0, 2, 2, 7, 32'h13);
    mem[4]  = enc_b(8, 2, 1);
    mem[5]  = enc_r(32'h20, 2, 1, 0, 8);
    mem[6]  = enc_r(0, 2, 1, 6, 9);
    mem[7]  = enc_i(32'hF0, 2, 7, 10, 32'h13);
    mem[8]  = enc_j(16, 6);
    mem[12] = 32'h0000_007F;
    wait_n = 0;
    do_reset(1'b0);
    step("c_addi_x1", 4);
    step("c_addi_x2", 4);
    step("addi_x0", 4);
    check("x0_stays_zero", dut.regs[0], 32'd0);
    step("slti_x7", 4);
    check("x7", dut.regs[7], 32'd1);
    step("beq_not_taken", 3);
    check("pc_beq_not_taken", pc_dbg, 32'h14);
    step("sub_x8", 4);
    check("x8", dut.regs[8], 32'd8);
    step("or_x9", 4);
    check("x9", dut.regs[9], 32'hFFFF_FFFD);
    step("andi_x10", 4);
    check("x10", dut.regs[10], 32'h0000_00F0);
    step("jal_x6", 3);
    check("x6", dut.regs[6], 32'h24);
    check("pc_jal", pc_dbg, 32'h30);
`ifdef CPU_MC_ILLEGAL_TRAP_EN
    repeat (3) @(negedge clk);
    n_req = 0;
    n_ret = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (mem_req === 1'b1) n_req++;
      if (retire === 1'b1) n_ret++;
    end
    check("halted", {31'b0, halted}, 32'd1);
    check("halt_no_req", 32'(n_req), 32'd0);
    check("halt_no_retire", 32'(n_ret), 32'd0);
    check("halt_pc", pc_dbg, 32'h30);
`else
    step("illegal_nop", 2);
    check("pc_after_nop", pc_dbg, 32'h34);
    check("not_halted", {31'b0, halted}, 32'd0);
    n_req = 0;
    n_ret = 0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
